sprite_move_ctrl: RTL

//  Parametrised grid-sprite location controller: next-generation pacman/ghost mover.

---
 rtl/sprite_move_ctrl.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_move_ctrl
//  Purpose  : Grid-sprite mover with continuous motion, queued turn, tick-divided
//             step rate, optional wrap-around and map/RAM req-ack handshakes.
//  Revision : 1.0
// ============================================================================
module sprite_move_ctrl #(
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int MAP_W    = 40,
    parameter int MAP_H    = 30,
    parameter int START_X  = 20,
    parameter int START_Y  = 20,
    parameter int STEP_DIV = 4,
    parameter int WRAP_EN  = 1,
    parameter int PILL_W   = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              tick,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    output logic              chk_valid,
    output logic [X_W-1:0]    chk_x,
    output logic [Y_W-1:0]    chk_y,
    input  logic              chk_ready,
    input  logic              chk_wall,
    input  logic              chk_pill,
    output logic              wr_req,
    output logic [X_W-1:0]    wr_new_x,
    output logic [Y_W-1:0]    wr_new_y,
    input  logic              wr_done,
    output logic [X_W-1:0]    curr_x,
    output logic [Y_W-1:0]    curr_y,
    output logic [1:0]        heading,
    output logic              moving,
    output logic [PILL_W-1:0] pill_count,
    output logic              busy
);

    localparam int                 c_CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STEP_DIV - 1);
    localparam logic [X_W-1:0]     c_X_MAX   = X_W'(MAP_W - 1);
    localparam logic [Y_W-1:0]     c_Y_MAX   = Y_W'(MAP_H - 1);
    localparam logic               c_BLK_EDGE = (WRAP_EN == 0);

    localparam logic [1:0] c_DIR_UP    = 2'b00;
    localparam logic [1:0] c_DIR_DOWN  = 2'b01;
    localparam logic [1:0] c_DIR_LEFT  = 2'b10;
    localparam logic [1:0] c_DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_CHK_TURN = 2'b01,
        S_CHK_FWD  = 2'b10,
        S_WRITE    = 2'b11
    } state_t;

    state_t              r_state_q,    w_state_d;
    logic [X_W-1:0]      r_curr_x_q,   w_curr_x_d;
    logic [Y_W-1:0]      r_curr_y_q,   w_curr_y_d;
    logic [X_W-1:0]      r_tgt_x_q,    w_tgt_x_d;
    logic [Y_W-1:0]      r_tgt_y_q,    w_tgt_y_d;
    logic                r_blocked_q,  w_blocked_d;
    logic [1:0]          r_heading_q,  w_heading_d;
    logic [1:0]          r_try_dir_q,  w_try_dir_d;
    logic [1:0]          r_pend_dir_q, w_pend_dir_d;
    logic                r_pend_vld_q, w_pend_vld_d;
    logic                r_moving_q,   w_moving_d;
    logic                r_pill_lat_q, w_pill_lat_d;
    logic [PILL_W-1:0]   r_pill_cnt_q, w_pill_cnt_d;
    logic [c_CNT_W-1:0]  r_step_cnt_q, w_step_cnt_d;
    logic                r_step_pend_q, w_step_pend_d;

    logic                w_idle;
    logic                w_step_hit;
    logic                w_step_go;
    logic                w_dir_req;
    logic [1:0]          w_dir_dec;
    logic [1:0]          w_calc_dir;
    logic [X_W-1:0]      w_calc_x;
    logic [Y_W-1:0]      w_calc_y;
    logic                w_calc_blk;
    logic                w_resp;
    logic                w_resp_wall;
    logic                w_pend_clr;

    assign w_idle     = (r_state_q == S_IDLE);
    assign w_step_hit = tick && (r_step_cnt_q == c_CNT_MAX);
    assign w_step_go  = w_idle && (r_step_pend_q || w_step_hit);
    assign w_dir_req  = up || down || left || right;
    assign w_dir_dec  = up ? c_DIR_UP : (down ? c_DIR_DOWN : (left ? c_DIR_LEFT : c_DIR_RIGHT));

    // A blocked edge target answers itself as a wall without touching the map port.
    assign w_resp      = r_blocked_q || chk_ready;
    assign w_resp_wall = r_blocked_q || chk_wall;

    // The queued turn is only tried from IDLE; every other target follows heading.
    assign w_calc_dir = (w_idle && r_pend_vld_q) ? r_pend_dir_q : r_heading_q;

    always_comb begin
        w_calc_x   = r_curr_x_q;
        w_calc_y   = r_curr_y_q;
        w_calc_blk = 1'b0;
        case (w_calc_dir)
            c_DIR_UP: begin
                if (r_curr_y_q == '0) begin
                    w_calc_y   = c_Y_MAX;
                    w_calc_blk = c_BLK_EDGE;
                end else begin
                    w_calc_y = r_curr_y_q - 1'b1;
                end
            end
            c_DIR_DOWN: begin
                if (r_curr_y_q == c_Y_MAX) begin
                    w_calc_y   = '0;
                    w_calc_blk = c_BLK_EDGE;
                end else begin
                    w_calc_y = r_curr_y_q + 1'b1;
                end
            end
            c_DIR_LEFT: begin
                if (r_curr_x_q == '0) begin
                    w_calc_x   = c_X_MAX;
                    w_calc_blk = c_BLK_EDGE;
                end else begin
                    w_calc_x = r_curr_x_q - 1'b1;
                end
            end
            c_DIR_RIGHT: begin
                if (r_curr_x_q == c_X_MAX) begin
                    w_calc_x   = '0;
                    w_calc_blk = c_BLK_EDGE;
                end else begin
                    w_calc_x = r_curr_x_q + 1'b1;
                end
            end
        endcase
    end

    // Ticks seen while busy saturate into one pending step.
    always_comb begin
        w_step_cnt_d  = r_step_cnt_q;
        w_step_pend_d = r_step_pend_q;
        if (w_idle) begin
            if (w_step_go) begin
                w_step_cnt_d  = '0;
                w_step_pend_d = 1'b0;
            end else if (tick) begin
                w_step_cnt_d = r_step_cnt_q + 1'b1;
            end
        end else if (tick) begin
            if (w_step_hit) begin
                w_step_pend_d = 1'b1;
            end else begin
                w_step_cnt_d = r_step_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_curr_x_d   = r_curr_x_q;
        w_curr_y_d   = r_curr_y_q;
        w_tgt_x_d    = r_tgt_x_q;
        w_tgt_y_d    = r_tgt_y_q;
        w_blocked_d  = r_blocked_q;
        w_heading_d  = r_heading_q;
        w_try_dir_d  = r_try_dir_q;
        w_pend_dir_d = r_pend_dir_q;
        w_pend_vld_d = r_pend_vld_q;
        w_moving_d   = r_moving_q;
        w_pill_lat_d = r_pill_lat_q;
        w_pill_cnt_d = r_pill_cnt_q;
        w_pend_clr   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (w_step_go && (r_pend_vld_q || r_moving_q)) begin
                    w_tgt_x_d   = w_calc_x;
                    w_tgt_y_d   = w_calc_y;
                    w_blocked_d = w_calc_blk;
                    w_try_dir_d = w_calc_dir;
                    w_state_d   = r_pend_vld_q ? S_CHK_TURN : S_CHK_FWD;
                end
            end
            S_CHK_TURN: begin
                if (w_resp) begin
                    if (w_resp_wall) begin
                        if (r_moving_q) begin
                            w_tgt_x_d   = w_calc_x;
                            w_tgt_y_d   = w_calc_y;
                            w_blocked_d = w_calc_blk;
                            w_try_dir_d = w_calc_dir;
                            w_state_d   = S_CHK_FWD;
                        end else begin
                            w_state_d = S_IDLE;
                        end
                    end else begin
                        w_heading_d  = r_try_dir_q;
                        w_pend_clr   = 1'b1;
                        w_pill_lat_d = chk_pill;
                        w_state_d    = S_WRITE;
                    end
                end
            end
            S_CHK_FWD: begin
                if (w_resp) begin
                    if (w_resp_wall) begin
                        w_moving_d = 1'b0;
                        w_state_d  = S_IDLE;
                    end else begin
                        w_pill_lat_d = chk_pill;
                        w_state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_done) begin
                    w_curr_x_d = r_tgt_x_q;
                    w_curr_y_d = r_tgt_y_q;
                    w_moving_d = 1'b1;
                    if (r_pill_lat_q && (r_pill_cnt_q != '1)) begin
                        w_pill_cnt_d = r_pill_cnt_q + 1'b1;
                    end
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        // A fresh key press outranks the clear from an accepted turn.
        if (w_pend_clr) begin
            w_pend_vld_d = 1'b0;
        end
        if (w_dir_req) begin
            w_pend_vld_d = 1'b1;
            w_pend_dir_d = w_dir_dec;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state_q     <= S_IDLE;
            r_curr_x_q    <= X_W'(START_X);
            r_curr_y_q    <= Y_W'(START_Y);
            r_tgt_x_q     <= X_W'(START_X);
            r_tgt_y_q     <= Y_W'(START_Y);
            r_blocked_q   <= 1'b0;
            r_heading_q   <= c_DIR_RIGHT;
            r_try_dir_q   <= c_DIR_RIGHT;
            r_pend_dir_q  <= c_DIR_RIGHT;
            r_pend_vld_q  <= 1'b0;
            r_moving_q    <= 1'b0;
            r_pill_lat_q  <= 1'b0;
            r_pill_cnt_q  <= '0;
            r_step_cnt_q  <= '0;
            r_step_pend_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_curr_x_q    <= w_curr_x_d;
            r_curr_y_q    <= w_curr_y_d;
            r_tgt_x_q     <= w_tgt_x_d;
            r_tgt_y_q     <= w_tgt_y_d;
            r_blocked_q   <= w_blocked_d;
            r_heading_q   <= w_heading_d;
            r_try_dir_q   <= w_try_dir_d;
            r_pend_dir_q  <= w_pend_dir_d;
            r_pend_vld_q  <= w_pend_vld_d;
            r_moving_q    <= w_moving_d;
            r_pill_lat_q  <= w_pill_lat_d;
            r_pill_cnt_q  <= w_pill_cnt_d;
            r_step_cnt_q  <= w_step_cnt_d;
            r_step_pend_q <= w_step_pend_d;
        end
    end

    assign chk_valid  = ((r_state_q == S_CHK_TURN) || (r_state_q == S_CHK_FWD)) && !r_blocked_q;
    assign chk_x      = r_tgt_x_q;
    assign chk_y      = r_tgt_y_q;
    assign wr_req     = (r_state_q == S_WRITE);
    assign wr_new_x   = r_tgt_x_q;
    assign wr_new_y   = r_tgt_y_q;
    assign curr_x     = r_curr_x_q;
    assign curr_y     = r_curr_y_q;
    assign heading    = r_heading_q;
    assign moving     = r_moving_q;
    assign pill_count = r_pill_cnt_q;
    assign busy       = !w_idle;

endmodule
`default_nettype wire
